// File: rtl/jt49_env.sv
// rtl/jt49_env.sv - PSG envelope generator: period-timed 32-step level ramp with hold/alternate/repeat shapes
module jt49_env #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          shape,
  input  logic                restart,
  output logic [4:0]          env,
  output logic                held
);

  localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  // shape bit positions: {CONT, ATT, ALT, HOLD}
  localparam int ALT_B = 1;

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [4:0]          pos_q, pos_d;
  logic                inv_q, inv_d;
  logic                held_q, held_d;
  logic [3:0]          shp_q, shp_d;

  logic [PERIOD_W-1:0] p_last;
  logic                tick;
  logic                step;

  // A zero period is treated as one tick per level; p_last is the final count of a level.
  assign p_last = (period == '0) ? '0 : (period - ONE);

  // Ticks are ignored once frozen; a step fires when the counter reaches (or was left above) the last count.
  assign tick = cen & ~held_q;
  assign step = tick & (cnt_q >= p_last);

  // Level is the cycle position, mirrored when the direction flag is set.
  assign env  = pos_q ^ {5{inv_q}};
  assign held = held_q;

  // Next-state: restart re-initialises and swallows any coincident tick; otherwise count and step.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    inv_d  = inv_q;
    held_d = held_q;
    shp_d  = shp_q;
    if (restart) begin
      shp_d  = shape;
      pos_d  = 5'd0;
      inv_d  = ~shape[2];
      held_d = 1'b0;
      cnt_d  = '0;
    end else if (tick) begin
      if (step) begin
        cnt_d = '0;
        if (pos_q != 5'd31) begin
          pos_d = pos_q + 5'd1;
        end else begin
          casez (shp_q)
            // one-shot: always come to rest silent
            4'b0???: begin
              held_d = 1'b1;
              inv_d  = 1'b1;
            end
            // continue + hold: freeze, optionally flipping to the opposite end
            4'b1??1: begin
              held_d = 1'b1;
              inv_d  = inv_q ^ shp_q[ALT_B];
            end
            // continue, no hold: wrap and run again, optionally reversed
            default: begin
              pos_d = 5'd0;
              inv_d = inv_q ^ shp_q[ALT_B];
            end
          endcase
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers; reset leaves the block frozen and silent until the first restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pos_q  <= 5'd31;
      inv_q  <= 1'b1;
      held_q <= 1'b1;
      shp_q  <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      inv_q  <= inv_d;
      held_q <= held_d;
      shp_q  <= shp_d;
    end
  end

endmodule

// File: tb/tb_jt49_env.sv
// tb/tb_jt49_env.sv - scoreboard bench for jt49_env: directed shapes, period boundaries, restart and async reset
module tb_jt49_env;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        cen     = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] period  = 16'd0;
  logic [3:0]  shape   = 4'd0;
  logic [4:0]  env;
  logic        held;

  jt49_env #(.PERIOD_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .period  (period),
    .shape   (shape),
    .restart (restart),
    .env     (env),
    .held    (held)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] cur_period = 16'd0;
  logic [3:0]  cur_shape  = 4'd0;

  int unsigned exp_cyc_q[$];
  logic [5:0]  exp_val_q[$];
  string       exp_nm_q[$];

  task automatic compare(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got env=%0d held=%0d, expected env=%0d held=%0d",
               nm, act[5:1], act[0], exp[5:1], exp[0]);
    end
  endtask

  // Drive one clock of stimulus and queue the env/held expected after that edge.
  task automatic tick(input logic c, input logic r, input logic [4:0] e, input logic h, input string nm);
    @(posedge clk);
    #1;
    cen     = c;
    restart = r;
    period  = cur_period;
    shape   = cur_shape;
    exp_cyc_q.push_back(cyc + 1);
    exp_val_q.push_back({e, h});
    exp_nm_q.push_back(nm);
  endtask

  // Monitor: pops the expectation that belongs to the current cycle and compares.
  string       mon_nm;
  logic [5:0]  mon_exp;
  int unsigned mon_cyc;
  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      mon_cyc = exp_cyc_q.pop_front();
      mon_exp = exp_val_q.pop_front();
      mon_nm  = exp_nm_q.pop_front();
      if (mon_cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", mon_nm, mon_cyc, cyc);
      end else begin
        compare(mon_nm, {env, held}, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_cyc_q.size());
    $fatal(1, "watchdog");
  end

  task automatic run_attack_hold(input logic [15:0] per, input string tag);
    logic [4:0] e;
    cur_period = per;
    cur_shape  = 4'b1101;
    tick(1'b0, 1'b1, 5'd0, 1'b0, {tag, " restart"});
    for (int k = 1; k <= 31; k++) begin
      e = 5'(k);
      tick(1'b1, 1'b0, e, 1'b0, $sformatf("%s ramp %0d", tag, k));
    end
    tick(1'b1, 1'b0, 5'd31, 1'b1, {tag, " freeze"});
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 5'd31, 1'b1, {tag, " held"});
  endtask

  initial begin
    int         ncen;
    int         s;
    logic [4:0] p;
    logic [4:0] e;

    #1 rst_n = 1'b0;
    #2 compare("reset_state", {env, held}, {5'd0, 1'b1});
    #9 rst_n = 1'b1;

    // frozen after reset: cen has no effect
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 5'd0, 1'b1, "post_reset_frozen");

    // attack + hold, period 1 and period 0
    run_attack_hold(16'd1, "att_hold_p1");
    run_attack_hold(16'd0, "att_hold_p0");

    // decay repeat, period 3, cen every 4th clock, three full sawtooth cycles
    cur_period = 16'd3;
    cur_shape  = 4'b1000;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "saw restart");
    ncen = 0;
    for (int i = 0; i < 32 * 12 * 3; i++) begin
      if (i % 4 == 3) ncen++;
      p = 5'((ncen / 3) % 32);
      e = 5'd31 - p;
      tick((i % 4 == 3), 1'b0, e, 1'b0, $sformatf("saw clk %0d", i));
    end

    // attack alternate triangle, period 2
    cur_period = 16'd2;
    cur_shape  = 4'b1110;
    tick(1'b0, 1'b1, 5'd0, 1'b0, "tri restart");
    for (int n = 1; n <= 160; n++) begin
      s = n / 2;
      p = 5'(s % 32);
      e = ((s / 32) % 2 == 1) ? (5'd31 - p) : p;
      tick(1'b1, 1'b0, e, 1'b0, $sformatf("tri tick %0d", n));
    end

    // one-shot decay ends silent and held
    cur_period = 16'd1;
    cur_shape  = 4'b0000;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "s0000 restart");
    for (int n = 1; n <= 31; n++) begin
      e = 5'd31 - 5'(n);
      tick(1'b1, 1'b0, e, 1'b0, $sformatf("s0000 tick %0d", n));
    end
    tick(1'b1, 1'b0, 5'd0, 1'b1, "s0000 end");
    tick(1'b1, 1'b0, 5'd0, 1'b1, "s0000 held");

    // decay, alternate, hold: jumps to 31 and stays
    cur_shape = 4'b1011;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "s1011 restart");
    for (int n = 1; n <= 31; n++) begin
      e = 5'd31 - 5'(n);
      tick(1'b1, 1'b0, e, 1'b0, $sformatf("s1011 tick %0d", n));
    end
    tick(1'b1, 1'b0, 5'd31, 1'b1, "s1011 end");
    tick(1'b1, 1'b0, 5'd31, 1'b1, "s1011 held");

    // restart coincident with a step-completing cen
    cur_period = 16'd3;
    cur_shape  = 4'b1000;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "coinc restart");
    tick(1'b1, 1'b0, 5'd31, 1'b0, "coinc t1");
    tick(1'b1, 1'b0, 5'd31, 1'b0, "coinc t2");
    tick(1'b1, 1'b0, 5'd30, 1'b0, "coinc t3 step");
    tick(1'b1, 1'b0, 5'd30, 1'b0, "coinc t4");
    tick(1'b1, 1'b0, 5'd30, 1'b0, "coinc t5");
    tick(1'b1, 1'b1, 5'd31, 1'b0, "coinc restart_on_step");
    tick(1'b1, 1'b0, 5'd31, 1'b0, "coinc after1");
    tick(1'b1, 1'b0, 5'd31, 1'b0, "coinc after2");
    tick(1'b1, 1'b0, 5'd30, 1'b0, "coinc after3 step");

    // lowering period below the running count steps on the next cen
    cur_period = 16'd100;
    tick(1'b0, 1'b1, 5'd31, 1'b0, "lower restart");
    for (int n = 1; n <= 50; n++) tick(1'b1, 1'b0, 5'd31, 1'b0, "lower count");
    cur_period = 16'd5;
    tick(1'b1, 1'b0, 5'd30, 1'b0, "lower step");
    for (int n = 1; n <= 4; n++) tick(1'b1, 1'b0, 5'd30, 1'b0, "lower level");
    tick(1'b1, 1'b0, 5'd29, 1'b0, "lower next step");

    // async reset mid-envelope at env=17
    cur_period = 16'd1;
    cur_shape  = 4'b1101;
    tick(1'b0, 1'b1, 5'd0, 1'b0, "mid restart");
    for (int k = 1; k <= 17; k++) begin
      e = 5'(k);
      tick(1'b1, 1'b0, e, 1'b0, "mid ramp");
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    cen   = 1'b0;
    rst_n = 1'b0;
    #1 compare("async_reset_no_edge", {env, held}, {5'd0, 1'b1});
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 5'd0, 1'b1, "after_reset_frozen");
    tick(1'b0, 1'b1, 5'd0, 1'b0, "after_reset restart");
    tick(1'b1, 1'b0, 5'd1, 1'b0, "after_reset step");
    tick(1'b0, 1'b0, 5'd1, 1'b0, "after_reset idle");

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_cyc_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jt49_env.md
# jt49_env

Envelope generator for the PSG. From the programmed 16-bit envelope period and 4-bit shape it produces the 5-bit envelope level that drives the `din` input of the exponential volume LUT. Its only time base is a one-cycle step-enable from the PSG clock divider. A shape-register write restarts the envelope.

## Interface
Parameters:
- `PERIOD_W`, 16: width of the period register and of the internal tick counter.

Ports:
- `clk`  in  1  system clock; one clock domain, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  tick enable, one-cycle pulse from the PSG divider.
- `period`  in  PERIOD_W  envelope period in `cen` ticks per level step; 0 behaves as 1.
- `shape`  in  4  {CONT, ATT, ALT, HOLD} (bit3..bit0).
- `restart`  in  1  one-cycle pulse on shape-register write.
- `env`  out  5  envelope level, 0 = silent, 31 = full; feeds the LUT `din`.
- `held`  out  1  high while the envelope is frozen.

## Operation
- Registers:
  - `cnt` [PERIOD_W], the tick counter.
  - `pos` [5], the position in the current 32-step cycle.
  - `inv`, the direction flag.
  - `held`.
  - `shp` [4], the shape latched at restart.
- `env = pos ^ {5{inv}}`. It is a pure function of registers, with no combinational path from inputs.
- Tick counter:
  - Active only when `cen`=1 and `held`=0.
  - `p_eff = (period==0) ? 1 : period`.
  - If `cnt >= p_eff-1`: `cnt`<=0 and an internal `step` is asserted this cycle. Otherwise `cnt`<=`cnt`+1.
  - `period` is sampled live. Lowering it below `cnt` causes a step on the next `cen`.
- On `step`:
  - If `pos`!=31: `pos`<=`pos`+1.
  - If `pos`==31, CONT=0: `held`<=1, `inv`<=1, `pos` stays 31, so `env`=0.
  - If `pos`==31, CONT=1, HOLD=1: `held`<=1, `inv`<=`inv`^ALT, `pos` stays 31.
  - If `pos`==31, CONT=1, HOLD=0: `pos`<=0, `inv`<=`inv`^ALT. The envelope repeats.
- Resulting frozen levels:
  - Shapes 00xx, 01xx, 1001, 1111 freeze at 0.
  - Shapes 1011, 1101 freeze at 31.
- On `restart`:
  - `shp`<=`shape`, `pos`<=0, `inv`<=~`shape`[2], `held`<=0, `cnt`<=0.
  - `env` becomes 0 for attack shapes (ATT=1) and 31 for decay shapes (ATT=0).
- `restart` has priority over `cen`/`step` in the same cycle. The coincident tick is discarded.
- While `held`=1, `cen` has no effect. `env` stays constant until the next `restart`.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - `cnt`=0, `pos`=31, `inv`=1, `held`=1, `shp`=0.
  - Therefore `env`=0 and `held`=1, and the block is silent until the first `restart`.
- Step latency: the `cen` cycle that completes a period updates `pos`/`inv` on that edge. The new `env` is visible the following cycle, a 1-cycle register latency.
- Restart latency: `env`/`held` reflect the new shape in the cycle after `restart`.
- Each level lasts exactly `p_eff` `cen` ticks. One full cycle is 32·`p_eff` ticks.
- Downstream, the LUT adds one more register. Total restart→LUT output latency is 2 cycles.
- Wrap: `pos` 31→0 occurs only in repeat mode (CONT=1, HOLD=0). It never occurs via overflow in hold modes.
- Reset asserted mid-envelope forces the reset state immediately, regardless of `cen`/`restart`.
- `restart` held high for several cycles re-initialises every cycle. The envelope starts counting after it drops.

## Test plan
- Reset, then `restart` with shape=4'b1101 (attack, hold), `period`=1, `cen` every cycle:
  - `env` steps 0,1,…,31, one value per cycle.
  - On the 32nd step it freezes at 31 and `held`=1.
  - Further `cen` pulses do not change `env`.
- Shape=4'b1000 (decay repeat), `period`=3, `cen` every 4th clock:
  - `env` runs 31→0, each level held 12 clocks, then returns to 31.
  - The sawtooth repeats across 3 full cycles.
- Shape=4'b1110 (attack, alternate), `period`=2:
  - `env` runs 0..31 then 31..0 (the 31 appears twice at the turn).
  - The triangle continues with `held`=0 throughout.
- Shape=4'b0000 and shape=4'b1011, `period`=1:
  - The first ends at 0 after 32 steps with `held`=1.
  - The second decays 31→0, then jumps to 31 and holds.
- Boundaries:
  - `period`=0 behaves identically to `period`=1.
  - `restart` coincident with a step-completing `cen` sets `pos`=0, and `cnt` restarts from 0.
  - Lowering `period` from 100 to 5 while `cnt`=50 steps on the next `cen`.
- Asynchronous reset pulsed while `env`=17 mid-cycle:
  - `env`=0 and `held`=1 with no clock edge.
  - They stay there until `restart`.
